object_move: RTL and testbench

- Position integrator for one flying object (fruit/bomb); sits directly downstream of the per-object velocity/acceleration stage.
- On each moveclk tick it adds the signed velocity (magnitude plus direction bits) to the current screen position.
- It detects when the object leaves the playfield and reports it to the spawner/score logic.
- Owns the object lifecycle: idle, flying, exiting.

---
 rtl/object_pkg.sv | 13 +
 rtl/axis_step.sv | 51 +++++
 rtl/object_move.sv | 111 +++++++++++
 tb/tb_object_move.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/object_pkg.sv
// Shared constants for the flying-object datapath: direction bit positions, screen extents, lifecycle states.
package object_pkg;
    localparam int DIR_MOVE_BIT = 1;
    localparam int DIR_INC_BIT  = 0;
    localparam int SCREEN_XMAX  = 639;
    localparam int SCREEN_YMAX  = 479;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        EXIT = 2'd2
    } state_t;
endpackage

// File: rtl/axis_step.sv
// Single-axis position step: signed move by magnitude+direction, flags leaving the range.
// Combinational. With WRAP=1 the axis wraps modulo MAX+1 instead of flagging (top enables it via WRAP_X_EN).
module axis_step
    import object_pkg::*;
#(
    parameter int W      = 10,
    parameter int MAX    = 639,
    parameter int MARGIN = 64,
    parameter bit WRAP   = 1'b0
) (
    input  logic [W-1:0] i_pos,
    input  logic [W-1:0] i_vel,
    input  logic [1:0]   i_dir,
    output logic [W-1:0] o_nxt,
    output logic         o_out
);
    localparam logic [W:0] LIM_EXIT = (W+1)'(MAX + MARGIN);
    localparam logic [W:0] LIM_WRAP = (W+1)'(MAX);
    localparam logic [W:0] SPAN     = (W+1)'(MAX + 1);

    logic [W:0] w_sum;
    logic [W:0] w_wrap_dn;

    assign w_sum     = {1'b0, i_pos} + {1'b0, i_vel};
    assign w_wrap_dn = {1'b0, i_pos} + SPAN - {1'b0, i_vel};

    always_comb begin
        o_nxt = i_pos;
        o_out = 1'b0;
        if (i_dir[DIR_MOVE_BIT]) begin
            if (i_dir[DIR_INC_BIT]) begin
                if (WRAP && (w_sum > LIM_WRAP)) begin
                    o_nxt = W'(w_sum - SPAN);
                end else if (!WRAP && (w_sum > LIM_EXIT)) begin
                    o_out = 1'b1;
                end else begin
                    o_nxt = w_sum[W-1:0];
                end
            end else if (i_vel > i_pos) begin
                // Underflow: either wrap to the far edge or leave the playfield
                if (WRAP) begin
                    o_nxt = w_wrap_dn[W-1:0];
                end else begin
                    o_out = 1'b1;
                end
            end else begin
                o_nxt = i_pos - i_vel;
            end
        end
    end
endmodule

// File: rtl/object_move.sv
// Position integrator and lifecycle FSM (IDLE/FLY/EXIT) for one flying object; one registered update per moveclk.
// Define WRAP_X_EN to make x wrap modulo XMAX+1 instead of exiting.
module object_move
    import object_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int XMAX     = SCREEN_XMAX,
    parameter int YMAX     = SCREEN_YMAX,
    parameter int MARGIN_X = 64,
    parameter int MARGIN_Y = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          moveclk,
    input  logic          launch,
    input  logic          kill,
    input  logic [XW-1:0] initx,
    input  logic [YW-1:0] inity,
    input  logic [XW-1:0] vx,
    input  logic [YW-1:0] vy,
    input  logic [1:0]    vdx,
    input  logic [1:0]    vdy,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          visible,
    output logic          exited
);
`ifdef WRAP_X_EN
    localparam bit X_WRAP = 1'b1;
`else
    localparam bit X_WRAP = 1'b0;
`endif

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_active;
    logic          r_exited;

    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_xout;
    logic          w_yout;

    axis_step #(.W(XW), .MAX(XMAX), .MARGIN(MARGIN_X), .WRAP(X_WRAP)) u_axis_x (
        .i_pos (r_x),
        .i_vel (vx),
        .i_dir (vdx),
        .o_nxt (w_nx),
        .o_out (w_xout)
    );

    axis_step #(.W(YW), .MAX(YMAX), .MARGIN(MARGIN_Y), .WRAP(1'b0)) u_axis_y (
        .i_pos (r_y),
        .i_vel (vy),
        .i_dir (vdy),
        .o_nxt (w_ny),
        .o_out (w_yout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_active <= 1'b0;
            r_exited <= 1'b0;
        end else begin
            r_exited <= 1'b0;
            if (kill) begin
                r_state  <= IDLE;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (launch) begin
                            r_x      <= initx;
                            r_y      <= inity;
                            r_active <= 1'b1;
                            r_state  <= FLY;
                        end
                    end
                    FLY: begin
                        if (moveclk) begin
                            // Out of range: keep last in-range position, drop active with the pulse
                            if (w_xout || w_yout) begin
                                r_state  <= EXIT;
                                r_active <= 1'b0;
                                r_exited <= 1'b1;
                            end else begin
                                r_x <= w_nx;
                                r_y <= w_ny;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    assign active  = r_active;
    assign exited  = r_exited;
    assign visible = r_active && (r_x <= XW'(XMAX)) && (r_y <= YW'(YMAX));
endmodule

// File: tb/tb_object_move.sv
// Directed bench for object_move: lifecycle, both axes, boundaries, priorities, optional x wrap.
module tb_object_move;
    logic       clk = 1'b0;
    logic       rst, moveclk, launch, kill;
    logic [9:0] initx, vx, x;
    logic [8:0] inity, vy, y;
    logic [1:0] vdx, vdy;
    logic       active, visible, exited;

    int checks = 0;
    int errors = 0;

    object_move dut (
        .clk(clk), .rst(rst), .moveclk(moveclk), .launch(launch), .kill(kill),
        .initx(initx), .inity(inity), .vx(vx), .vy(vy), .vdx(vdx), .vdy(vdy),
        .x(x), .y(y), .active(active), .visible(visible), .exited(exited)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_launch(input logic [9:0] ix, input logic [8:0] iy);
        initx = ix; inity = iy; launch = 1'b1;
        step();
        launch = 1'b0;
    endtask

    task automatic do_kill();
        moveclk = 1'b0; kill = 1'b1;
        step();
        kill = 1'b0;
    endtask

    task automatic tick();
        moveclk = 1'b1;
        step();
        moveclk = 1'b0;
    endtask

    task automatic test_reset();
        x_init_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (x !== 10'd0) begin errors++; $display("FAIL reset_x got %0d exp 0", x); end
        checks++; if (y !== 9'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", y); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", active); end
        checks++; if (exited !== 1'b0) begin errors++; $display("FAIL reset_exited got %b exp 0", exited); end
    endtask

    task automatic x_init_inputs();
        moveclk = 0; launch = 0; kill = 0;
        initx = 0; inity = 0; vx = 0; vy = 0; vdx = 2'b00; vdy = 2'b00;
    endtask

    task automatic test_basic_flight();
        vx = 10'd4; vdx = 2'b11; vy = 9'd10; vdy = 2'b10;
        do_launch(10'd320, 9'd470);
        checks++; if (x !== 10'd320 || y !== 9'd470 || active !== 1'b1)
            begin errors++; $display("FAIL launch_load got x=%0d y=%0d act=%b exp 320 470 1", x, y, active); end
        // moveclk held high for three consecutive cycles
        moveclk = 1'b1;
        step(); step(); step();
        moveclk = 1'b0;
        checks++; if (x !== 10'd332) begin errors++; $display("FAIL basic_x got %0d exp 332", x); end
        checks++; if (y !== 9'd440) begin errors++; $display("FAIL basic_y got %0d exp 440", y); end
        checks++; if (active !== 1'b1 || visible !== 1'b1)
            begin errors++; $display("FAIL basic_flags got act=%b vis=%b exp 1 1", active, visible); end
        do_kill();
        checks++; if (active !== 1'b0 || exited !== 1'b0)
            begin errors++; $display("FAIL kill_idle got act=%b exit=%b exp 0 0", active, exited); end
    endtask

`ifndef WRAP_X_EN
    task automatic test_x_zero_then_exit();
        vx = 10'd2; vdx = 2'b10; vy = 9'd0; vdy = 2'b00;
        do_launch(10'd2, 9'd100);
        tick();
        checks++; if (x !== 10'd0 || active !== 1'b1 || exited !== 1'b0)
            begin errors++; $display("FAIL x_zero got x=%0d act=%b exit=%b exp 0 1 0", x, active, exited); end
        tick();
        checks++; if (exited !== 1'b1 || active !== 1'b0 || x !== 10'd0)
            begin errors++; $display("FAIL x_under_exit got exit=%b act=%b x=%0d exp 1 0 0", exited, active, x); end
        step();
        checks++; if (exited !== 1'b0 || active !== 1'b0)
            begin errors++; $display("FAIL exit_one_cycle got exit=%b act=%b exp 0 0", exited, active); end
    endtask

    task automatic test_x_right_exit();
        vx = 10'd40; vdx = 2'b11; vy = 9'd0; vdy = 2'b00;
        do_launch(10'd630, 9'd100);
        tick();
        checks++; if (x !== 10'd670 || visible !== 1'b0 || active !== 1'b1)
            begin errors++; $display("FAIL x_margin got x=%0d vis=%b act=%b exp 670 0 1", x, visible, active); end
        tick();
        checks++; if (exited !== 1'b1 || x !== 10'd670)
            begin errors++; $display("FAIL x_right_exit got exit=%b x=%0d exp 1 670", exited, x); end
        step();
    endtask
`else
    task automatic test_wrap_x();
        vx = 10'd5; vdx = 2'b11; vy = 9'd0; vdy = 2'b00;
        do_launch(10'd637, 9'd100);
        tick();
        checks++; if (x !== 10'd2 || exited !== 1'b0 || active !== 1'b1)
            begin errors++; $display("FAIL wrap_inc got x=%0d exit=%b act=%b exp 2 0 1", x, exited, active); end
        do_kill();
        vdx = 2'b10;
        do_launch(10'd2, 9'd100);
        tick();
        checks++; if (x !== 10'd637 || exited !== 1'b0 || active !== 1'b1)
            begin errors++; $display("FAIL wrap_dec got x=%0d exit=%b act=%b exp 637 0 1", x, exited, active); end
        do_kill();
    endtask
`endif

    task automatic test_y_exit();
        vx = 10'd0; vdx = 2'b00; vy = 9'd10; vdy = 2'b11;
        do_launch(10'd100, 9'd490);
        checks++; if (visible !== 1'b0 || active !== 1'b1)
            begin errors++; $display("FAIL y490_visible got vis=%b act=%b exp 0 1", visible, active); end
        tick();
        checks++; if (y !== 9'd500) begin errors++; $display("FAIL y_step got %0d exp 500", y); end
        vy = 9'd20;
        tick();
        checks++; if (exited !== 1'b1 || active !== 1'b0 || y !== 9'd500)
            begin errors++; $display("FAIL y_exit got exit=%b act=%b y=%0d exp 1 0 500", exited, active, y); end
        step();
        checks++; if (exited !== 1'b0) begin errors++; $display("FAIL y_exit_pulse got %b exp 0", exited); end
    endtask

    task automatic test_kill_priority();
        vx = 10'd5; vdx = 2'b10; vy = 9'd0; vdy = 2'b00;
        do_launch(10'd2, 9'd100);
        moveclk = 1'b1; kill = 1'b1;
        step();
        moveclk = 1'b0; kill = 1'b0;
        checks++; if (active !== 1'b0 || exited !== 1'b0)
            begin errors++; $display("FAIL kill_vs_exit got act=%b exit=%b exp 0 0", active, exited); end
        step();
        checks++; if (exited !== 1'b0) begin errors++; $display("FAIL kill_no_pulse got %b exp 0", exited); end
        // launch while flying must not reload
        vx = 10'd0; vdx = 2'b00;
        do_launch(10'd100, 9'd100);
        do_launch(10'd200, 9'd200);
        checks++; if (x !== 10'd100 || y !== 9'd100 || active !== 1'b1)
            begin errors++; $display("FAIL fly_relaunch got x=%0d y=%0d act=%b exp 100 100 1", x, y, active); end
        do_kill();
    endtask

    task automatic test_launch_with_tick();
        vx = 10'd5; vdx = 2'b11; vy = 9'd0; vdy = 2'b00;
        initx = 10'd50; inity = 9'd60; launch = 1'b1; moveclk = 1'b1;
        step();
        launch = 1'b0; moveclk = 1'b0;
        checks++; if (x !== 10'd50) begin errors++; $display("FAIL launch_tick got x=%0d exp 50", x); end
        tick();
        checks++; if (x !== 10'd55) begin errors++; $display("FAIL after_launch_tick got x=%0d exp 55", x); end
        do_kill();
    endtask

    initial begin
        test_reset();
        test_basic_flight();
`ifndef WRAP_X_EN
        test_x_zero_then_exit();
        test_x_right_exit();
`else
        test_wrap_x();
`endif
        test_y_exit();
        test_kill_priority();
        test_launch_with_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
